// File: rtl/dot_accum_requant.sv
// dot_accum_requant
//   Consumes the naive_dot partial-result stream (one signed partial per
//   in_valid beat, no backpressure), sums cfg_k partials into one dot product,
//   adds a bias, requantizes to OUT_WIDTH bits (round-half-up arithmetic shift,
//   optional ReLU, saturation) and queues results in a small output FIFO.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   in_valid/in_data  partial-product beat (signed IN_WIDTH)
//   cfg_k           partials per output (0 behaves as 1)
//   cfg_shift       right-shift amount 0..15
//   cfg_bias        signed bias added to each group sum
//   cfg_relu        clamp negative results to zero
//   out_valid/out_ready/out_data  FIFO head, valid/ready handshake
//   busy            a group is partly accumulated
//   ovf             sticky; a result was dropped on a full FIFO
module dot_accum_requant #(
    parameter int IN_WIDTH   = 16,
    parameter int ACC_WIDTH  = 26,
    parameter int OUT_WIDTH  = 8,
    parameter int K_WIDTH    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [K_WIDTH-1:0]   cfg_k,
    input  logic [3:0]           cfg_shift,
    input  logic [IN_WIDTH-1:0]  cfg_bias,
    input  logic                 cfg_relu,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 busy,
    output logic                 ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic signed [ACC_WIDTH-1:0] Q_MAX = ACC_WIDTH'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] Q_MIN = -Q_MAX - ACC_WIDTH'(1);

    // accumulation stage
    logic [K_WIDTH-1:0]          cnt_q, cnt_d;
    logic [K_WIDTH-1:0]          k_q, k_d;
    logic [3:0]                  shift_q, shift_d;
    logic signed [ACC_WIDTH-1:0] bias_q, bias_d;
    logic                        relu_q, relu_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

    // requant stage input
    logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
    logic                        st_vld_q, st_vld_d;
    logic [3:0]                  st_shift_q, st_shift_d;
    logic                        st_relu_q, st_relu_d;

    logic                        first;
    logic [K_WIDTH-1:0]          k_eff;
    logic signed [ACC_WIDTH-1:0] bias_eff;
    logic [3:0]                  shift_eff;
    logic                        relu_eff;
    logic signed [ACC_WIDTH-1:0] in_ext;
    logic signed [ACC_WIDTH-1:0] acc_sum;

    // On the first beat of a group the live cfg inputs are used directly, so
    // a k=1 group closes on the same beat that captures its configuration.
    always_comb begin
        first     = (cnt_q == '0);
        k_eff     = first ? ((cfg_k == '0) ? K_WIDTH'(1) : cfg_k) : k_q;
        bias_eff  = first ? {{(ACC_WIDTH-IN_WIDTH){cfg_bias[IN_WIDTH-1]}}, cfg_bias} : bias_q;
        shift_eff = first ? cfg_shift : shift_q;
        relu_eff  = first ? cfg_relu : relu_q;
        in_ext    = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        acc_sum   = (first ? '0 : acc_q) + in_ext;

        cnt_d      = cnt_q;
        k_d        = k_q;
        shift_d    = shift_q;
        bias_d     = bias_q;
        relu_d     = relu_q;
        acc_d      = acc_q;
        sum_d      = sum_q;
        st_vld_d   = 1'b0;
        st_shift_d = st_shift_q;
        st_relu_d  = st_relu_q;

        if (in_valid) begin
            if (first) begin
                k_d     = k_eff;
                shift_d = shift_eff;
                bias_d  = bias_eff;
                relu_d  = relu_eff;
            end
            acc_d = acc_sum;
            if (cnt_q == k_eff - K_WIDTH'(1)) begin
                cnt_d      = '0;
                sum_d      = acc_sum + bias_eff;
                st_vld_d   = 1'b1;
                // shift/relu travel with the sum: the next group may already
                // have re-captured the shadow registers.
                st_shift_d = shift_eff;
                st_relu_d  = relu_eff;
            end else begin
                cnt_d = cnt_q + K_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            k_q        <= '0;
            shift_q    <= '0;
            bias_q     <= '0;
            relu_q     <= 1'b0;
            acc_q      <= '0;
            sum_q      <= '0;
            st_vld_q   <= 1'b0;
            st_shift_q <= '0;
            st_relu_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            shift_q    <= shift_d;
            bias_q     <= bias_d;
            relu_q     <= relu_d;
            acc_q      <= acc_d;
            sum_q      <= sum_d;
            st_vld_q   <= st_vld_d;
            st_shift_q <= st_shift_d;
            st_relu_q  <= st_relu_d;
        end
    end

    // requantize
    logic signed [ACC_WIDTH-1:0] rnd;
    logic signed [ACC_WIDTH-1:0] rounded;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [ACC_WIDTH-1:0] clamped;
    logic [OUT_WIDTH-1:0]        q_val;

    always_comb begin
        rnd     = (st_shift_q != 4'd0) ? (ACC_WIDTH'(1) << (st_shift_q - 4'd1)) : '0;
        rounded = sum_q + rnd;
        shifted = rounded >>> st_shift_q;
        clamped = shifted;
        if (st_relu_q && (shifted < 0)) begin
            clamped = '0;
        end
        if (clamped > Q_MAX) begin
            clamped = Q_MAX;
        end else if (clamped < Q_MIN) begin
            clamped = Q_MIN;
        end
        q_val = clamped[OUT_WIDTH-1:0];
    end

    // output FIFO; count kept apart from the pointers to tell full from empty
    logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     fcnt_q;
    logic                 ovf_q;
    logic                 pop, full, push_ok, drop;

    always_comb begin
        pop     = (fcnt_q != '0) && out_ready;
        full    = (fcnt_q == CNT_W'(FIFO_DEPTH));
        push_ok = st_vld_q && (!full || pop);
        drop    = st_vld_q && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= q_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fcnt_q <= fcnt_q + CNT_W'(push_ok) - CNT_W'(pop);
            ovf_q  <= ovf_q | drop;
        end
    end

    assign out_valid = (fcnt_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign busy      = (cnt_q != '0);
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dot_accum_requant.sv
module tb_dot_accum_requant;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [7:0]  cfg_k = 8'd1;
    logic [3:0]  cfg_shift = '0;
    logic [15:0] cfg_bias = '0;
    logic        cfg_relu = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        busy;
    logic        ovf;

    dot_accum_requant dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .cfg_k(cfg_k), .cfg_shift(cfg_shift), .cfg_bias(cfg_bias), .cfg_relu(cfg_relu),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: partials of the open group, captured group config,
    // one result in flight to the FIFO, and the FIFO contents
    longint m_parts[$];
    int     m_k, m_shift, m_relu;
    longint m_bias;
    bit     m_st_vld;
    longint m_st_val;
    longint m_fifo[$];
    bit     m_ovf;
    longint got_q[$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint requant(longint sum, int sh, int relu);
        longint r;
        r = sum + ((sh > 0) ? (longint'(1) << (sh - 1)) : 0);
        r = r >>> sh;
        if (relu != 0 && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic model_step();
        bit     pop;
        bit     new_vld;
        longint new_val;
        longint sum;
        if (rst) begin
            m_parts.delete();
            m_fifo.delete();
            m_st_vld = 0;
            m_ovf = 0;
            return;
        end
        pop = (m_fifo.size() > 0) && out_ready;
        new_vld = 0;
        new_val = 0;
        if (in_valid) begin
            if (m_parts.size() == 0) begin
                m_k     = (cfg_k == 0) ? 1 : int'(cfg_k);
                m_shift = int'(cfg_shift);
                m_bias  = longint'($signed(cfg_bias));
                m_relu  = int'(cfg_relu);
            end
            m_parts.push_back(longint'($signed(in_data)));
            if (m_parts.size() == m_k) begin
                sum = m_bias;
                foreach (m_parts[i]) sum += m_parts[i];
                new_val = requant(sum, m_shift, m_relu);
                new_vld = 1;
                m_parts.delete();
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (m_st_vld) begin
            if (m_fifo.size() == DEPTH) m_ovf = 1;
            else m_fifo.push_back(m_st_val);
        end
        m_st_vld = new_vld;
        m_st_val = new_val;
    endtask

    task automatic tick();
        if (out_valid && out_ready) got_q.push_back(longint'($signed(out_data)));
        @(posedge clk);
        model_step();
        #1;
        chk("out_valid", longint'(out_valid), longint'(m_fifo.size() != 0));
        chk("out_data", longint'($signed(out_data)), (m_fifo.size() != 0) ? m_fifo[0] : 0);
        chk("busy", longint'(busy), longint'(m_parts.size() != 0));
        chk("ovf", longint'(ovf), longint'(m_ovf));
    endtask

    task automatic beat(input int d);
        in_valid = 1'b1;
        in_data  = 16'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cfg(input int k, input int sh, input int bias, input int relu);
        cfg_k     = 8'(k);
        cfg_shift = 4'(sh);
        cfg_bias  = 16'(bias);
        cfg_relu  = 1'(relu);
    endtask

    task automatic chk_got(input string tag, input int idx, input longint exp);
        chk(tag, (idx < got_q.size()) ? got_q[idx] : 9999, exp);
    endtask

    initial begin
        // reset
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_ovf", longint'(ovf), 0);

        // 1: pass-through with saturation, 2-cycle latency
        set_cfg(1, 0, 0, 0);
        out_ready = 1'b1;
        got_q.delete();
        beat(5);
        chk("t1_lat_e0", longint'(out_valid), 0);
        beat(-3);
        chk("t1_lat_e1", longint'(out_valid), 1);
        chk("t1_first", longint'($signed(out_data)), 5);
        beat(200);
        idle(4);
        chk_got("t1_o0", 0, 5);
        chk_got("t1_o1", 1, -3);
        chk_got("t1_o2", 2, 127);
        chk("t1_ovf", longint'(ovf), 0);

        // 2: four-beat group with rounding, then k=1 negative rounding
        got_q.delete();
        set_cfg(4, 2, 0, 0);
        beat(100); beat(200); beat(-50); beat(30);
        set_cfg(1, 1, 0, 0);
        beat(-7);
        idle(4);
        chk_got("t2_k4", 0, 70);
        chk_got("t2_k1", 1, -3);

        // 3: relu, bias, and cfg_k change mid-group
        got_q.delete();
        set_cfg(2, 0, 0, 1);
        beat(-10); beat(3);
        set_cfg(2, 0, 20, 1);
        beat(-10);
        cfg_k = 8'd1;
        chk("t3_busy", longint'(busy), 1);
        beat(3);
        idle(4);
        chk_got("t3_relu", 0, 0);
        chk_got("t3_bias", 1, 13);
        chk("t3_count", longint'(got_q.size()), 2);

        // 4: overflow with out_ready low
        got_q.delete();
        set_cfg(1, 0, 0, 0);
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) beat(i);
        idle(3);
        chk("t4_valid", longint'(out_valid), 1);
        chk("t4_ovf", longint'(ovf), 1);
        out_ready = 1'b1;
        idle(6);
        chk("t4_count", longint'(got_q.size()), 4);
        for (int i = 0; i < 4; i++) chk_got("t4_order", i, longint'(i + 1));
        chk("t4_empty", longint'(out_valid), 0);

        // 5: reset mid-group
        got_q.delete();
        set_cfg(4, 0, 0, 0);
        beat(7); beat(7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", longint'(busy), 0);
        chk("t5_ovf", longint'(ovf), 0);
        beat(1); beat(1); beat(1); beat(1);
        idle(4);
        chk("t5_count", longint'(got_q.size()), 1);
        chk_got("t5_out", 0, 4);

        // 6: negative saturation, then push+pop while full
        got_q.delete();
        set_cfg(2, 8, 0, 0);
        beat(-32768); beat(-32768);
        idle(4);
        chk_got("t6_sat", 0, -128);
        got_q.delete();
        set_cfg(1, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            out_ready = (i >= 6);
            beat(i * 9 - 60);
        end
        idle(8);
        chk("t6_ovf", longint'(ovf), 0);
        chk("t6_count", longint'(got_q.size()), 12);
        for (int i = 1; i <= 12; i++) chk_got("t6_order", i - 1, longint'(i * 9 - 60));

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: in_data = 16'h8000;
                1: in_data = 16'h7fff;
                default: in_data = 16'($urandom);
            endcase
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                cfg_k     = 8'($urandom_range(0, 5));
                cfg_shift = 4'($urandom_range(0, 15));
                cfg_bias  = 16'($urandom);
                cfg_relu  = 1'($urandom_range(0, 1));
            end
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(8);
        chk("final_empty", longint'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dot_accum_requant.md
Name: dot_accum_requant

Overview:
- Downstream consumer of the naive_dot engine's result stream, which delivers one 16-bit signed partial dot product per cycle on done/result with no backpressure.
- Sums cfg_k consecutive partials into one long-vector dot product (vector length N*cfg_k), adds a bias, then requantizes to 8 bits with shift, round, optional ReLU and saturation.
- Buffers the 8-bit results in a small FIFO behind a valid/ready output port.

Parameters:
IN_WIDTH, 16, partial-result width (signed)
ACC_WIDTH, 26, accumulator width (signed); holds 255 × full-scale input plus bias without wrap
OUT_WIDTH, 8, requantized output width (signed)
K_WIDTH, 8, width of cfg_k
FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  partial valid; driven by naive_dot done
in_data  in  IN_WIDTH  signed partial; driven by naive_dot result
cfg_k  in  K_WIDTH  partials per output; 0 treated as 1
cfg_shift  in  4  arithmetic right-shift amount, 0..15
cfg_bias  in  IN_WIDTH  signed bias, sign-extended to ACC_WIDTH
cfg_relu  in  1  1 = clamp negative sums to 0 before saturation
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accepts out_data
out_data  out  OUT_WIDTH  signed requantized result (FIFO head)
busy  out  1  group in progress (beat counter ≠ 0)
ovf  out  1  sticky; a result was dropped because the FIFO was full

Behaviour:
- Reset values: out_valid=0, out_data=0, busy=0, ovf=0. Reset also clears the beat counter, accumulator, pipeline-valid bit and FIFO pointers/count. Reset mid-group discards the partial sum.
- Config shadowing: cfg_k, cfg_shift, cfg_bias and cfg_relu are captured on the first beat of each group (in_valid while counter=0). Changes during a group have no effect until the next group.
- Accumulate, per in_valid beat:
  - If counter=0: acc ← sext(in_data).
  - Otherwise: acc ← acc + sext(in_data).
  - Counter increments each beat.
  - On the last beat (counter = k_shadow−1, where k_shadow = max(cfg_k,1)): compute sum = acc_prev + sext(in_data) + sext(bias), register it in the requant stage with stage_valid=1, and reset counter to 0.
  - in_valid=0 leaves all state unchanged; gaps between beats are allowed.
- Requant stage (combinational on registered sum):
  - r = (sum + (shift>0 ? 1<<(shift−1) : 0)) >>> shift. This is round-half-up, arithmetic shift.
  - If relu and r<0: r=0.
  - Saturate r to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
- FIFO write: when stage_valid=1, push r on the next edge.
- Latency: last beat sampled at edge E0 → sum registered at E0 → FIFO write at E1 → out_valid=1 in the cycle after E1. Minimum last-beat-to-out_valid latency is 2 cycles.
- Sustained rate with k=1: one output per cycle, no bubbles.
- Output handshake:
  - A transfer occurs when out_valid & out_ready at a clock edge.
  - out_data is stable while out_valid=1 and out_ready=0.
  - FIFO order is preserved.
- Full FIFO:
  - A push with count=FIFO_DEPTH and no pop in the same cycle is dropped, and ovf is set (cleared only by rst).
  - Simultaneous push and pop while full is accepted: count stays FIFO_DEPTH, no drop.
- Empty FIFO: out_ready is ignored. A push into an empty FIFO appears on out_data the next cycle.
- Pointer wrap: read/write pointers wrap modulo FIFO_DEPTH. Count is tracked separately to distinguish full from empty.
- busy = (counter ≠ 0). It does not reflect stage/FIFO occupancy.

Test Plan:
1. k=1, shift=0, bias=0, relu=0, out_ready=1; in 5, −3, 200 on consecutive cycles → out 5, −3, 127, each 2 cycles after its input; ovf=0.
2. k=4, shift=2; in 100, 200, −50, 30 → sum 280 → (282>>>2) = out 70. Then k=1, shift=1, in −7 → out −3.
3. k=2, relu=1; in −10, 3 → out 0. Same with bias=20 → out 13. cfg_k changed to 1 after the first beat → that group still takes 2 beats.
4. k=1, out_ready=0, FIFO_DEPTH=4; in 1..6 → out_valid=1, ovf=1, only 4 stored. Then out_ready=1 → outputs 1, 2, 3, 4 in order, then out_valid=0.
5. k=4; in 7, 7; rst one cycle; then in 1, 1, 1, 1 → busy 0 after reset, single out 4, ovf=0.
6. k=2, shift=8; in −32768, −32768 → (−65408>>>8) = −256 → saturated out −128. Full-FIFO simultaneous push/pop with out_ready=1 at steady k=1 stream → no drops, ovf stays 0.
